// File: rtl/cache_nway.sv
// N-way set-associative write-back, write-allocate cache between a 32-bit CPU port and a
// line-wide physical memory port. Replacement prefers invalid ways, then tree pseudo-LRU.
module cache_nway #(
    parameter int unsigned s_offset = 5,
    parameter int unsigned s_index  = 3,
    parameter int unsigned s_tag    = 32 - s_offset - s_index,
    parameter int unsigned num_ways = 4,
    parameter int unsigned s_line   = 8 * 2**s_offset
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       mem_address,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [3:0]        mem_byte_enable,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_resp,
    output logic [31:0]       pmem_address,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [s_line-1:0] pmem_wdata,
    input  logic [s_line-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam int unsigned num_sets  = 2**s_index;
    localparam int unsigned s_way     = $clog2(num_ways);
    localparam int unsigned s_word    = (s_offset > 2) ? s_offset - 2 : 1;
    localparam int unsigned num_words = 2**(s_offset - 2);
    localparam int unsigned num_nodes = num_ways - 1;

    typedef logic [s_way-1:0]     way_t;
    typedef logic [num_nodes-1:0] plru_t;

    typedef enum logic [1:0] {StCheck, StWriteback, StFill} state_e;

    // Tree nodes are heap-ordered; the root splits on way bit 0, the next level on bit 1, etc.
    // A node bit of 0 means the branch-0 subtree is least recently used.
    function automatic way_t plru_victim(input plru_t bits);
        way_t way;
        int   node;
        logic b;
        way  = '0;
        node = 0;
        for (int d = 0; d < s_way; d++) begin
            b = 1'b0;
            for (int n = 0; n < num_nodes; n++) begin
                if (n == node) b = bits[n];
            end
            way[d] = b;
            node   = (2 << d) - 1 + int'(way);
        end
        return way;
    endfunction

    function automatic plru_t plru_update(input plru_t bits, input way_t way);
        plru_t res;
        int    node;
        int    prefix;
        res    = bits;
        prefix = 0;
        for (int d = 0; d < s_way; d++) begin
            node = (1 << d) - 1 + prefix;
            for (int n = 0; n < num_nodes; n++) begin
                if (n == node) res[n] = ~way[d];
            end
            prefix = prefix + (int'(way[d]) << d);
        end
        return res;
    endfunction

    logic [s_tag-1:0]    addr_tag;
    logic [s_index-1:0]  addr_index;
    logic [s_word-1:0]   addr_word;
    logic [31:0]         fill_addr;
    logic                unused_addr_lsb;

    assign addr_tag        = mem_address[31 -: s_tag];
    assign addr_index      = mem_address[s_offset +: s_index];
    assign addr_word       = s_word'(mem_address[s_offset-1:0] >> 2);
    assign fill_addr       = {addr_tag, addr_index, {s_offset{1'b0}}};
    assign unused_addr_lsb = ^mem_address[1:0];

    logic [s_tag-1:0]    tag_q   [num_ways][num_sets];
    logic [s_line-1:0]   data_q  [num_ways][num_sets];
    logic [num_ways-1:0] valid_q [num_sets];
    logic [num_ways-1:0] dirty_q [num_sets];
    plru_t               plru_q  [num_sets];

    state_e      state_q;
    way_t        victim_q;
    logic        pmem_read_q;
    logic        pmem_write_q;
    logic [31:0] pmem_address_q;

    logic hit;
    way_t hit_way;
    logic inv_found;
    way_t inv_way;
    way_t miss_victim;
    logic victim_dirty;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < num_ways; w++) begin
            if (valid_q[addr_index][w] && (tag_q[w][addr_index] == addr_tag)) begin
                hit     = 1'b1;
                hit_way = way_t'(w);
            end
        end
    end

    // Scan downwards so the lowest-numbered invalid way wins.
    always_comb begin
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = num_ways - 1; w >= 0; w--) begin
            if (!valid_q[addr_index][w]) begin
                inv_found = 1'b1;
                inv_way   = way_t'(w);
            end
        end
        miss_victim  = inv_found ? inv_way : plru_victim(plru_q[addr_index]);
        victim_dirty = valid_q[addr_index][miss_victim] && dirty_q[addr_index][miss_victim];
    end

    logic req;
    logic access_hit;
    logic write_hit;
    logic fill_done;

    assign req        = mem_read | mem_write;
    assign access_hit = (state_q == StCheck) && req && hit;
    assign write_hit  = access_hit && mem_write;
    assign fill_done  = (state_q == StFill) && pmem_resp;

    logic [s_line-1:0] hit_line;
    logic [s_line-1:0] merged_line;
    logic [31:0]       hit_word;

    always_comb begin
        hit_line    = data_q[hit_way][addr_index];
        merged_line = hit_line;
        hit_word    = '0;
        for (int i = 0; i < num_words; i++) begin
            if (s_word'(i) == addr_word) begin
                hit_word = hit_line[32*i +: 32];
                for (int b = 0; b < 4; b++) begin
                    if (mem_byte_enable[b]) begin
                        merged_line[32*i + 8*b +: 8] = mem_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    assign mem_resp     = access_hit;
    assign mem_rdata    = access_hit ? hit_word : '0;
    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = pmem_address_q;
    assign pmem_wdata   = pmem_write_q ? data_q[victim_q][addr_index] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StCheck;
            victim_q       <= '0;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
        end else begin
            unique case (state_q)
                StCheck: begin
                    if (req && !hit) begin
                        victim_q <= miss_victim;
                        if (victim_dirty) begin
                            state_q        <= StWriteback;
                            pmem_write_q   <= 1'b1;
                            pmem_address_q <= {tag_q[miss_victim][addr_index], addr_index,
                                               {s_offset{1'b0}}};
                        end else begin
                            state_q        <= StFill;
                            pmem_read_q    <= 1'b1;
                            pmem_address_q <= fill_addr;
                        end
                    end
                end
                StWriteback: begin
                    if (pmem_resp) begin
                        state_q        <= StFill;
                        pmem_write_q   <= 1'b0;
                        pmem_read_q    <= 1'b1;
                        pmem_address_q <= fill_addr;
                    end
                end
                StFill: begin
                    if (pmem_resp) begin
                        state_q        <= StCheck;
                        pmem_read_q    <= 1'b0;
                        pmem_address_q <= '0;
                    end
                end
                default: state_q <= StCheck;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < num_sets; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            if (fill_done) begin
                valid_q[addr_index][victim_q] <= 1'b1;
                dirty_q[addr_index][victim_q] <= 1'b0;
            end
            if (write_hit) begin
                dirty_q[addr_index][hit_way] <= 1'b1;
            end
            if (access_hit) begin
                plru_q[addr_index] <= plru_update(plru_q[addr_index], hit_way);
            end
        end
    end

    // Data and tags carry no reset; valid bits gate every use of them.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            data_q[victim_q][addr_index] <= pmem_rdata;
            tag_q[victim_q][addr_index]  <= addr_tag;
        end else if (write_hit) begin
            data_q[hit_way][addr_index] <= merged_line;
        end
    end

endmodule

// File: doc/cache_nway.md
Name: cache_nway

Overview:
- Parametrised N-way set-associative, write-back, write-allocate cache.
- Sits between the CPU memory port (32-bit word, byte mask) and physical memory (one full line per transfer).
- Successor to the fixed 2-way cache: way count, set count and line size are generic, and replacement uses tree pseudo-LRU with invalid-way priority.
- Single module: tag/valid/dirty/PLRU/data storage, control FSM and word/line adaptation.

Parameters:
- s_offset, 5, byte-offset bits; line = 2**s_offset bytes, s_offset >= 2.
- s_index, 3, set-index bits; num_sets = 2**s_index.
- s_tag, 32-s_offset-s_index, tag bits.
- num_ways, 4, associativity; power of two, >= 2.
- s_line, 8*2**s_offset, line width in bits (pmem data width).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- mem_address  in  32  CPU byte address.
- mem_read  in  1  CPU read request; held until mem_resp.
- mem_write  in  1  CPU write request; held until mem_resp; never asserted with mem_read.
- mem_byte_enable  in  4  write byte mask, bit i = byte lane i.
- mem_wdata  in  32  write data.
- mem_rdata  out  32  read data; valid while mem_resp=1.
- mem_resp  out  1  one-cycle completion pulse.
- pmem_address  out  32  line-aligned address; low s_offset bits are 0.
- pmem_read  out  1  line fill request; held until pmem_resp.
- pmem_write  out  1  line writeback request; held until pmem_resp.
- pmem_wdata  out  s_line  victim line data.
- pmem_rdata  in  s_line  fill data; valid when pmem_resp=1.
- pmem_resp  in  1  physical memory completion.

Behaviour:
- Address split: tag = [31 : s_offset+s_index], index = [s_offset+s_index-1 : s_offset], word = [s_offset-1 : 2].
- Reset (rst=0, asynchronous):
  - All valid, dirty and PLRU bits cleared; FSM to CHECK.
  - mem_resp, pmem_read and pmem_write = 0; pmem_address = 0.
  - Data and tag arrays need not be cleared.
  - Reset mid-transfer aborts it; pmem_read/pmem_write drop immediately; no partial line is marked valid.
- FSM states: CHECK, WRITEBACK, FILL.
- CHECK, idle (no request): all outputs 0.
- CHECK, request present: hit = any way w with valid[w][index] and tag[w][index]==tag. At most one way hits.
  - Hit, same cycle (combinational): mem_resp=1; mem_rdata = word `word` of the hit line.
  - Hit write, at clock edge: merge mem_wdata into that word under mem_byte_enable and set dirty.
  - Hit read or write, at clock edge: update PLRU for the set.
- Miss: victim = lowest-numbered invalid way, else the PLRU way. Victim is latched at the miss edge and used through WRITEBACK and FILL.
  - Victim valid and dirty -> WRITEBACK.
  - Otherwise -> FILL.
- WRITEBACK:
  - pmem_write=1; pmem_address = {victim tag, index, 0}; pmem_wdata = victim line.
  - On pmem_resp -> FILL; pmem_write drops the following cycle.
- FILL:
  - pmem_read=1; pmem_address = {tag, index, 0}.
  - On pmem_resp, write pmem_rdata into the victim way; set valid; clear dirty; write tag; -> CHECK.
  - Request then hits in CHECK, which performs the write merge.
- Latency: hit = 0 extra cycles (resp in first CHECK cycle). Clean miss = fill time + 2. Dirty miss = writeback + fill + 2.
- PLRU: num_ways-1 bits per set, binary tree, node bit 0 = left subtree LRU.
  - On access, every node on the path is set to point away from the accessed way.
  - Victim = follow the bits from the root.
- pmem_read and pmem_write are never both 1. No new pmem request is issued in the cycle pmem_resp is seen.
- A request changing while mem_resp=0 is illegal; behaviour is undefined.
- mem_byte_enable=0 on a write hit: mem_resp asserts, data unchanged, line still marked dirty.

Test Plan (num_ways=4, s_index=3, s_offset=5):
- Read 0x0000_0040 after reset -> no writeback; pmem_read with pmem_address=0x40; after pmem_resp, mem_resp with the word 0 of the fill line; a repeat read hits with mem_resp in the first cycle.
- Write 0xDEADBEEF, mask 4'b0101, to 0x44 (already cached, old word 0x11223344) -> next read of 0x44 returns 0x11AD33EF; no pmem activity.
- Fill tags 0..3 into set 2 (0x040, 0x140, 0x240, 0x340), then touch ways 0,1,2 -> access to 0x440 evicts way 3 (tag 3); pmem_address=0x440.
- Dirty eviction: write 0x040, then force its eviction -> pmem_write with pmem_address=0x040 and the modified line, pmem_write low before pmem_read rises, fill address = new line.
- rst pulled low during FILL -> pmem_read drops the same cycle; after release, a read of the same address misses again.
- Different sets are independent: fill set 0 and set 7 with the same tag -> both hit; PLRU in set 0 is unaffected by set-7 accesses.
